// File: rtl/glitch_pkg.sv
// glitch_pkg: shared types and constants for the glitch sequencer.
//   - state_t    : sequencer states
//   - status_t   : registered status/strobe bundle and its decode function
//   - EDGE_*     : trigger edge select encodings
//   - *_DEF      : default field widths
package glitch_pkg;

    localparam int DELAY_W_DEF     = 32;
    localparam int WIDTH_W_DEF     = 16;
    localparam int COUNT_W_DEF     = 8;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        PULSE = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic armed;
        logic waiting;
        logic firing;
        logic glitch;
        logic done;
    } status_t;

    // Output flags that must be visible while the sequencer sits in state s.
    // Loading this alongside the next state keeps every output registered.
    function automatic status_t status_of(input state_t s);
        status_t st;
        st = '0;
        case (s)
            ARMED:   st.armed   = 1'b1;
            DELAY:   st.waiting = 1'b1;
            PULSE: begin
                st.firing = 1'b1;
                st.glitch = 1'b1;
            end
            GAP:     st.firing  = 1'b1;
            DONE:    st.done    = 1'b1;
            default: st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/glitch_sequencer_trig_sync.sv
// trig_sync: synchronizes the asynchronous trigger pin and detects the
// selected edge.
//   clk, reset  : system clock, synchronous active-high reset
//   trig        : raw asynchronous trigger pin
//   falling     : edge select (EDGE_RISING / EDGE_FALLING)
//   preload     : asserted in the cycle the sequencer enters ARMED
//   edge_pulse  : single-cycle pulse when the selected edge is seen
// SYNC_STAGES must be at least 2.
module trig_sync
    import glitch_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    input  logic falling,
    input  logic preload,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   level;
    logic                   hist;
    logic                   rise;
    logic                   fall;

    assign level = chain[SYNC_STAGES-1];

    // Synchronizer chain plus one-cycle history of the synced level. The
    // history always follows the level, so at ARMED entry it already holds
    // the present level and a level that was static at arm time never fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            hist  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], trig};
            hist  <= level;
        end
    end

    assign rise = level & ~hist;
    assign fall = ~level & hist;

    // The arming cycle is masked: the edge-select value is still being latched.
    assign edge_pulse = ~preload & ((falling == EDGE_RISING) ? rise : fall);

endmodule

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: trigger-armed pulse-train timing controller.
//   clk, reset      : 100 MHz system clock, synchronous active-high reset
//   i_arm/i_disarm  : arm strobe (latches config) / abort strobe
//   i_trig          : asynchronous trigger pin; i_trig_falling selects edge
//   i_delay         : cycles from trigger detect to first pulse
//   i_width, i_gap  : pulse high / low cycles (0 treated as 1)
//   i_count         : number of pulses (0 treated as 1)
//   i_mux           : output-select mask, latched at arm
//   o_glitch        : registered raw glitch strobe
//   o_output_mux    : latched mask, 0 while idle
//   o_armed/o_waiting/o_firing : status for LED PWMs
//   o_done          : one-cycle strobe on normal completion
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int DELAY_W     = DELAY_W_DEF,
    parameter int WIDTH_W     = WIDTH_W_DEF,
    parameter int COUNT_W     = COUNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_arm,
    input  logic               i_disarm,
    input  logic               i_trig,
    input  logic               i_trig_falling,
    input  logic [DELAY_W-1:0] i_delay,
    input  logic [WIDTH_W-1:0] i_width,
    input  logic [WIDTH_W-1:0] i_gap,
    input  logic [COUNT_W-1:0] i_count,
    input  logic [7:0]         i_mux,
    output logic               o_glitch,
    output logic [7:0]         o_output_mux,
    output logic               o_armed,
    output logic               o_waiting,
    output logic               o_firing,
    output logic               o_done
);

    state_t             state;
    status_t            status;
    logic [DELAY_W-1:0] lat_delay;
    logic [DELAY_W-1:0] delay_cnt;
    logic [WIDTH_W-1:0] lat_width;
    logic [WIDTH_W-1:0] lat_gap;
    logic [WIDTH_W-1:0] phase_cnt;
    logic [COUNT_W-1:0] lat_count;
    logic [COUNT_W-1:0] pulses_left;
    logic               lat_falling;
    logic [7:0]         mux_reg;
    logic               arm_accept;
    logic               trig_edge;

    assign arm_accept = (state == IDLE) && i_arm && !i_disarm;

    trig_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_trig_sync (
        .clk       (clk),
        .reset     (reset),
        .trig      (i_trig),
        .falling   (lat_falling),
        .preload   (arm_accept),
        .edge_pulse(trig_edge)
    );

    // Sequencer FSM. Counters load with their full period and end the phase
    // when they read 1; zero widths/gaps/counts are promoted to 1 at latch
    // time so every phase lasts at least one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            status      <= '0;
            mux_reg     <= 8'd0;
            lat_delay   <= '0;
            lat_width   <= '0;
            lat_gap     <= '0;
            lat_count   <= '0;
            lat_falling <= EDGE_RISING;
            delay_cnt   <= '0;
            phase_cnt   <= '0;
            pulses_left <= '0;
        end else if (state != IDLE && i_disarm) begin
            state   <= IDLE;
            status  <= status_of(IDLE);
            mux_reg <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm_accept) begin
                        lat_delay   <= i_delay;
                        lat_width   <= (i_width == '0) ? WIDTH_W'(1) : i_width;
                        lat_gap     <= (i_gap == '0) ? WIDTH_W'(1) : i_gap;
                        lat_count   <= (i_count == '0) ? COUNT_W'(1) : i_count;
                        lat_falling <= i_trig_falling;
                        mux_reg     <= i_mux;
                        state       <= ARMED;
                        status      <= status_of(ARMED);
                    end else begin
                        mux_reg <= 8'd0;
                        state   <= IDLE;
                        status  <= status_of(IDLE);
                    end
                end
                ARMED: begin
                    if (trig_edge) begin
                        pulses_left <= lat_count;
                        if (lat_delay == '0) begin
                            phase_cnt <= lat_width;
                            state     <= PULSE;
                            status    <= status_of(PULSE);
                        end else begin
                            delay_cnt <= lat_delay;
                            state     <= DELAY;
                            status    <= status_of(DELAY);
                        end
                    end else begin
                        state <= ARMED;
                    end
                end
                DELAY: begin
                    if (delay_cnt == DELAY_W'(1)) begin
                        phase_cnt <= lat_width;
                        state     <= PULSE;
                        status    <= status_of(PULSE);
                    end else begin
                        delay_cnt <= delay_cnt - DELAY_W'(1);
                    end
                end
                PULSE: begin
                    if (phase_cnt == WIDTH_W'(1)) begin
                        // Last pulse goes straight to DONE: no trailing gap.
                        if (pulses_left == COUNT_W'(1)) begin
                            state  <= DONE;
                            status <= status_of(DONE);
                        end else begin
                            pulses_left <= pulses_left - COUNT_W'(1);
                            phase_cnt   <= lat_gap;
                            state       <= GAP;
                            status      <= status_of(GAP);
                        end
                    end else begin
                        phase_cnt <= phase_cnt - WIDTH_W'(1);
                    end
                end
                GAP: begin
                    if (phase_cnt == WIDTH_W'(1)) begin
                        phase_cnt <= lat_width;
                        state     <= PULSE;
                        status    <= status_of(PULSE);
                    end else begin
                        phase_cnt <= phase_cnt - WIDTH_W'(1);
                    end
                end
                DONE: begin
                    mux_reg <= 8'd0;
                    state   <= IDLE;
                    status  <= status_of(IDLE);
                end
                default: begin
                    mux_reg <= 8'd0;
                    state   <= IDLE;
                    status  <= status_of(IDLE);
                end
            endcase
        end
    end

    assign o_glitch     = status.glitch;
    assign o_armed      = status.armed;
    assign o_waiting    = status.waiting;
    assign o_firing     = status.firing;
    assign o_done       = status.done;
    assign o_output_mux = mux_reg;

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: randomized + directed bench for glitch_sequencer.
// A behavioural model expands each armed train into a queue of per-cycle
// phases (wait / high / low / done) and a compare process checks every
// output against it at each falling clock edge. Directed scenarios add
// hand-computed literal expectations (latencies, bit patterns, counts).
module tb_glitch_sequencer;

    localparam int S = 2;

    logic        clk;
    logic        reset;
    logic        i_arm;
    logic        i_disarm;
    logic        i_trig;
    logic        i_trig_falling;
    logic [31:0] i_delay;
    logic [15:0] i_width;
    logic [15:0] i_gap;
    logic [7:0]  i_count;
    logic [7:0]  i_mux;
    logic        o_glitch;
    logic [7:0]  o_output_mux;
    logic        o_armed;
    logic        o_waiting;
    logic        o_firing;
    logic        o_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    glitch_sequencer #(
        .DELAY_W(32), .WIDTH_W(16), .COUNT_W(8), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset(reset), .i_arm(i_arm), .i_disarm(i_disarm),
        .i_trig(i_trig), .i_trig_falling(i_trig_falling),
        .i_delay(i_delay), .i_width(i_width), .i_gap(i_gap),
        .i_count(i_count), .i_mux(i_mux),
        .o_glitch(o_glitch), .o_output_mux(o_output_mux), .o_armed(o_armed),
        .o_waiting(o_waiting), .o_firing(o_firing), .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_ARMED, M_TRAIN} mode_t;
    localparam int C_WAIT = 0, C_HIGH = 1, C_LOW = 2, C_DONE = 3, C_ARMED = 4;

    mode_t      mode = M_IDLE;
    int         q[$];
    logic [S+1:0] h;
    int         m_delay, m_width, m_gap, m_count;
    bit         m_fall;
    logic [7:0] m_mux;
    bit         mvalid = 0;
    logic       e_glitch, e_armed, e_waiting, e_firing, e_done;
    logic [7:0] e_mux;

    task automatic set_idle();
        mode = M_IDLE;
        q.delete();
        {e_glitch, e_armed, e_waiting, e_firing, e_done} = 5'b0;
        e_mux = 8'd0;
    endtask

    task automatic show(input int code);
        e_glitch  = (code == C_HIGH);
        e_firing  = (code == C_HIGH) || (code == C_LOW);
        e_waiting = (code == C_WAIT);
        e_done    = (code == C_DONE);
        e_armed   = (code == C_ARMED);
        e_mux     = m_mux;
    endtask

    task automatic model_step();
        bit det;
        cyc++;
        if (reset) begin
            set_idle();
            h = '0;
            mvalid = 1;
            return;
        end
        h = {h[S:0], i_trig};
        det = m_fall ? (h[S+1] && !h[S]) : (!h[S+1] && h[S]);
        case (mode)
            M_IDLE: begin
                if (i_arm && !i_disarm) begin
                    m_delay = int'(i_delay);
                    m_width = (i_width == 0) ? 1 : int'(i_width);
                    m_gap   = (i_gap == 0) ? 1 : int'(i_gap);
                    m_count = (i_count == 0) ? 1 : int'(i_count);
                    m_fall  = i_trig_falling;
                    m_mux   = i_mux;
                    mode    = M_ARMED;
                    show(C_ARMED);
                end else begin
                    set_idle();
                end
            end
            M_ARMED: begin
                if (i_disarm) set_idle();
                else if (det) begin
                    q.delete();
                    for (int i = 0; i < m_delay; i++) q.push_back(C_WAIT);
                    for (int p = 0; p < m_count; p++) begin
                        for (int i = 0; i < m_width; i++) q.push_back(C_HIGH);
                        if (p < m_count - 1)
                            for (int i = 0; i < m_gap; i++) q.push_back(C_LOW);
                    end
                    q.push_back(C_DONE);
                    mode = M_TRAIN;
                    show(q.pop_front());
                end else begin
                    show(C_ARMED);
                end
            end
            default: begin
                if (i_disarm || q.size() == 0) set_idle();
                else show(q.pop_front());
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every output against the model each cycle.
    always @(negedge clk) begin
        if (mvalid) begin
            check("glitch",  o_glitch,     e_glitch);
            check("armed",   o_armed,      e_armed);
            check("waiting", o_waiting,    e_waiting);
            check("firing",  o_firing,     e_firing);
            check("done",    o_done,       e_done);
            check("mux",     o_output_mux, e_mux);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input int d, input int w, input int g, input int c,
                           input bit f, input logic [7:0] m);
        i_delay = 32'(d); i_width = 16'(w); i_gap = 16'(g);
        i_count = 8'(c);  i_trig_falling = f; i_mux = m;
    endtask

    task automatic arm();
        i_arm = 1'b1;
        tick(1);
        i_arm = 1'b0;
    endtask

    task automatic run_train(input int t0, input int budget, input int toggle_at,
                             output int rise, output int highs, output int dones,
                             output logic [13:0] bits, output logic [7:0] mux_at_rise);
        int nb;
        rise = -1; highs = 0; dones = 0; bits = '0; mux_at_rise = '0; nb = 0;
        for (int t = 0; t < budget; t++) begin
            if (toggle_at >= 0 && (t == toggle_at || t == toggle_at + 3)) i_trig = ~i_trig;
            tick(1);
            if (o_glitch) begin
                if (rise < 0) begin
                    rise = cyc - t0;
                    mux_at_rise = o_output_mux;
                end
                highs++;
            end
            if (rise >= 0 && nb < 14) begin
                bits = {bits[12:0], o_glitch};
                nb++;
            end
            if (o_done) dones++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, highs, dones, t0, n;
        logic [13:0] bits;
        logic [7:0]  mr;

        reset = 1'b1; i_arm = 1'b0; i_disarm = 1'b0; i_trig = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0, 8'h00);
        tick(3);
        check("reset_glitch", o_glitch, 0);
        check("reset_status", {o_armed, o_waiting, o_firing, o_done}, 0);
        check("reset_mux", o_output_mux, 0);
        reset = 1'b0;
        tick(5);

        // 1: delay=10, width=5, count=1, rising
        set_cfg(10, 5, 0, 1, 1'b0, 8'hA5);
        arm();
        tick(3);
        i_trig = 1'b1; t0 = cyc;
        run_train(t0, 30, -1, rise, highs, dones, bits, mr);
        check("t1_latency", rise, 13);
        check("t1_highs", highs, 5);
        check("t1_done", dones, 1);
        check("t1_mux_train", mr, 8'hA5);
        check("t1_mux_after", o_output_mux, 0);

        // 2: count=3, width=2, gap=4, second edge mid-train ignored
        i_trig = 1'b0; tick(5);
        set_cfg(3, 2, 4, 3, 1'b0, 8'h3C);
        arm();
        tick(2);
        i_trig = 1'b1; t0 = cyc;
        run_train(t0, 35, 8, rise, highs, dones, bits, mr);
        check("t2_latency", rise, 6);
        check("t2_pattern", bits, 14'b11000011000011);
        check("t2_highs", highs, 6);
        check("t2_done", dones, 1);
        check("t2_idle", o_armed, 0);

        // 3: all-zero fields -> one 1-cycle pulse at edge+1
        i_trig = 1'b0; tick(5);
        set_cfg(0, 0, 0, 0, 1'b0, 8'h01);
        arm();
        tick(2);
        i_trig = 1'b1; t0 = cyc;
        run_train(t0, 15, -1, rise, highs, dones, bits, mr);
        check("t3_latency", rise, 3);
        check("t3_highs", highs, 1);
        check("t3_done", dones, 1);

        // 4a: trig high at arm, falling selected
        tick(5);
        set_cfg(1, 1, 1, 1, 1'b1, 8'h02);
        arm();
        tick(10);
        check("t4a_still_armed", o_armed, 1);
        check("t4a_no_fire", o_waiting | o_firing, 0);
        i_trig = 1'b0; t0 = cyc;
        run_train(t0, 15, -1, rise, highs, dones, bits, mr);
        check("t4a_latency", rise, 4);
        check("t4a_done", dones, 1);

        // 4b: trig high at arm, rising selected: needs a toggle
        i_trig = 1'b1; tick(5);
        set_cfg(1, 1, 1, 1, 1'b0, 8'h04);
        arm();
        tick(10);
        check("t4b_still_armed", o_armed, 1);
        i_trig = 1'b0; tick(3);
        check("t4b_low_no_fire", o_armed, 1);
        i_trig = 1'b1; t0 = cyc;
        run_train(t0, 15, -1, rise, highs, dones, bits, mr);
        check("t4b_latency", rise, 4);

        // 5: disarm during a long pulse
        i_trig = 1'b0; tick(5);
        set_cfg(0, 100, 1, 1, 1'b0, 8'h08);
        arm();
        tick(2);
        i_trig = 1'b1;
        n = 0;
        while (!o_glitch && n < 20) begin tick(1); n++; end
        check("t5_pulse_started", o_glitch, 1);
        tick(3);
        i_disarm = 1'b1; tick(1); i_disarm = 1'b0;
        check("t5_glitch_low", o_glitch, 0);
        check("t5_idle", {o_armed, o_waiting, o_firing}, 0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin tick(1); if (o_done) dones++; end
        check("t5_no_done", dones, 0);
        i_arm = 1'b1; i_disarm = 1'b1; tick(1);
        i_arm = 1'b0; i_disarm = 1'b0;
        check("t5_arm_disarm", o_armed, 0);
        tick(3);
        check("t5_stays_idle", o_armed, 0);

        // 6a: reset during DELAY
        i_trig = 1'b0; tick(5);
        set_cfg(50, 2, 1, 1, 1'b0, 8'h10);
        arm();
        tick(2);
        i_trig = 1'b1;
        n = 0;
        while (!o_waiting && n < 10) begin tick(1); n++; end
        check("t6_in_delay", o_waiting, 1);
        tick(5);
        reset = 1'b1; tick(1); reset = 1'b0;
        check("t6_reset_outs", {o_glitch, o_armed, o_waiting, o_firing, o_done}, 0);
        check("t6_reset_mux", o_output_mux, 0);

        // 6b: re-arm while ARMED keeps the original values
        i_trig = 1'b0; tick(5);
        set_cfg(2, 3, 1, 1, 1'b0, 8'h11);
        arm();
        tick(2);
        set_cfg(20, 7, 2, 3, 1'b1, 8'h22);
        arm();
        tick(2);
        i_trig = 1'b1; t0 = cyc;
        run_train(t0, 40, -1, rise, highs, dones, bits, mr);
        check("t6b_latency", rise, 5);
        check("t6b_highs", highs, 3);
        check("t6b_mux", mr, 8'h11);
        check("t6b_done", dones, 1);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            set_cfg($urandom_range(0, 8), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom));
            i_arm    = ($urandom_range(0, 9) == 0);
            i_disarm = ($urandom_range(0, 79) == 0);
            reset    = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 5) == 0) i_trig = ~i_trig;
            tick(1);
        end
        i_arm = 1'b0; i_disarm = 1'b0; reset = 1'b0;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
